// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Holds the FSM state encoding, default width, counter sizing and the most-negative operand.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [MD_WIDTH-1:0] INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV,
    ST_DIV_FIX,
    ST_DONE
  } md_state_e;

  // The counter must hold WIDTH itself, since it increments past the last step.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes; purely combinational, zero latency.
// Shifts the next dividend bit into the remainder and subtracts the divisor when it fits.
module div_restore_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign fits   = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= dvs_i);
  assign diff   = rem_sh[WIDTH-1:0] - dvs_i;

  assign rem_o = fits ? diff : rem_sh[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// Signed Booth multiply / restoring divide with architectural HI/LO registers.
// Latency 33 (mul) / 35 (div) / 1 (div by zero); starts while not idle are dropped.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mult_start,
  input  logic             div_start,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             qm1_q, qm1_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Booth step: the extra adder bit keeps the sign correct when the multiplicand is INT_MIN.
  logic [WIDTH:0]   booth_hi_ext, booth_mc_ext, booth_sum;
  logic [WIDTH-1:0] booth_hi, booth_lo;
  logic             booth_qm1;

  assign booth_hi_ext = {acc_hi_q[WIDTH-1], acc_hi_q};
  assign booth_mc_ext = {mcand_q[WIDTH-1], mcand_q};

  always_comb begin
    booth_sum = booth_hi_ext;
    case ({acc_lo_q[0], qm1_q})
      2'b01:   booth_sum = booth_hi_ext + booth_mc_ext;
      2'b10:   booth_sum = booth_hi_ext - booth_mc_ext;
      default: booth_sum = booth_hi_ext;
    endcase
  end

  assign booth_hi  = booth_sum[WIDTH:1];
  assign booth_lo  = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
  assign booth_qm1 = acc_lo_q[0];

  logic [WIDTH-1:0] div_rem, div_quo;

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_hi_q),
    .quo_i (acc_lo_q),
    .dvs_i (mcand_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    qm1_d    = qm1_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mult_start) begin
          state_d  = ST_MUL;
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          qm1_d    = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else if (div_start) begin
          if (b == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d  = ST_DIV_PREP;
            mcand_d  = b;
            acc_lo_d = a;
            acc_hi_d = '0;
            busy_d   = 1'b1;
          end
        end
      end

      ST_MUL: begin
        acc_hi_d = booth_hi;
        acc_lo_d = booth_lo;
        qm1_d    = booth_qm1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          hi_d    = booth_hi;
          lo_d    = booth_lo;
        end else begin
          busy_d = 1'b1;
        end
      end

      ST_DIV_PREP: begin
        q_neg_d  = acc_lo_q[WIDTH-1] ^ mcand_q[WIDTH-1];
        r_neg_d  = acc_lo_q[WIDTH-1];
        acc_lo_d = acc_lo_q[WIDTH-1] ? -acc_lo_q : acc_lo_q;
        mcand_d  = mcand_q[WIDTH-1] ? -mcand_q : mcand_q;
        acc_hi_d = '0;
        cnt_d    = '0;
        state_d  = ST_DIV;
        busy_d   = 1'b1;
      end

      ST_DIV: begin
        acc_hi_d = div_rem;
        acc_lo_d = div_quo;
        cnt_d    = cnt_q + CNT_W'(1);
        busy_d   = 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DIV_FIX;
        end
      end

      // INT_MIN / -1 leaves an unsigned quotient of 2^(W-1) with q_neg clear, which reads back as INT_MIN.
      ST_DIV_FIX: begin
        lo_d    = q_neg_q ? -acc_lo_q : acc_lo_q;
        hi_d    = r_neg_q ? -acc_hi_q : acc_hi_q;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qm1_q    <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      qm1_q    <= qm1_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed products, quotients and cycle counts.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mult_start = 1'b0;
  logic         div_start = 1'b0;
  logic [W-1:0] hi_out, lo_out;
  logic         busy, done, div_zero;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .mult_start (mult_start),
    .div_start  (div_start),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start on the next edge (edge 0) and scrambles the operands afterwards.
  task automatic start_op(input logic m, input logic d, input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    mult_start = m;
    div_start = d;
    tick();
    mult_start = 1'b0;
    div_start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
  endtask

  // Returns the cycle index in which done is seen (bounded); flags busy/done overlap.
  task automatic wait_done(input int inject_div_at, output int cyc, output logic busy1, output logic overlap);
    cyc = 1;
    busy1 = busy;
    overlap = 1'b0;
    while (!done && cyc < 200) begin
      if (busy && done) overlap = 1'b1;
      if (cyc == inject_div_at) begin
        a = 32'd50;
        b = 32'd5;
        div_start = 1'b1;
      end
      tick();
      div_start = 1'b0;
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  int   cyc;
  logic busy1, ovl;

  initial begin
    #2;
    check("rst_hi", {32'h0, hi_out}, 64'h0);
    check("rst_lo", {32'h0, lo_out}, 64'h0);
    check("rst_ctl", {61'h0, busy, done, div_zero}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 7 * -3
    start_op(1'b1, 1'b0, 32'd7, -32'sd3);
    wait_done(-1, cyc, busy1, ovl);
    check("mul1_cyc", 64'(cyc), 64'd33);
    check("mul1_busy1", {63'h0, busy1}, 64'h1);
    check("mul1_res", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul1_busy_at_done", {63'h0, busy}, 64'h0);
    check("mul1_ovl", {63'h0, ovl}, 64'h0);
    tick();
    check("mul1_done_pulse", {63'h0, done}, 64'h0);
    check("mul1_hold", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    // INT_MIN * INT_MIN
    start_op(1'b1, 1'b0, INT_MIN, INT_MIN);
    wait_done(-1, cyc, busy1, ovl);
    check("mul2_res", {hi_out, lo_out}, 64'h4000_0000_0000_0000);
    tick();

    // INT_MIN * 3
    start_op(1'b1, 1'b0, INT_MIN, 32'd3);
    wait_done(-1, cyc, busy1, ovl);
    check("mul3_res", {hi_out, lo_out}, 64'hFFFF_FFFE_8000_0000);
    tick();

    // -7 / 2
    start_op(1'b0, 1'b1, -32'sd7, 32'd2);
    wait_done(-1, cyc, busy1, ovl);
    check("div1_cyc", 64'(cyc), 64'd35);
    check("div1_res", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div1_dz", {63'h0, div_zero}, 64'h0);
    check("div1_ovl", {63'h0, ovl}, 64'h0);
    tick();

    // 5 / 0: result registers keep -7/2 outcome
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    check("dz_done", {62'h0, done, div_zero}, 64'h3);
    check("dz_busy", {63'h0, busy}, 64'h0);
    check("dz_hold", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    tick();
    check("dz_clear", {62'h0, done, div_zero}, 64'h0);

    // 7 / -2
    start_op(1'b0, 1'b1, 32'd7, -32'sd2);
    wait_done(-1, cyc, busy1, ovl);
    check("div2_res", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFD);
    tick();

    // INT_MIN / -1
    start_op(1'b0, 1'b1, INT_MIN, -32'sd1);
    wait_done(-1, cyc, busy1, ovl);
    check("div3_res", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    tick();

    // simultaneous starts: multiply wins; stray div_start at cycle 10 ignored
    start_op(1'b1, 1'b1, 32'd3, 32'd4);
    wait_done(10, cyc, busy1, ovl);
    check("both_cyc", 64'(cyc), 64'd33);
    check("both_res", {hi_out, lo_out}, 64'h0000_0000_0000_000C);
    check("both_dz", {63'h0, div_zero}, 64'h0);
    tick();
    check("both_idle", {62'h0, busy, done}, 64'h0);

    // asynchronous reset in cycle 15 of a divide
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    for (int i = 1; i < 15; i++) tick();
    check("pre_rst_busy", {63'h0, busy}, 64'h1);
    reset = 1'b0;
    #1;
    check("arst_hilo", {hi_out, lo_out}, 64'h0);
    check("arst_ctl", {61'h0, busy, done, div_zero}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // fresh 100 / 7 after reset
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done(-1, cyc, busy1, ovl);
    check("div4_cyc", 64'(cyc), 64'd35);
    check("div4_res", {hi_out, lo_out}, 64'h0000_0002_0000_000E);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Sequential signed multiply/divide engine with architectural HI/LO registers, serving the multicycle CPU's `mult`/`div` instructions. It takes operands straight from the A/B operand registers, runs a radix-2 Booth multiply or a restoring divide over multiple cycles, and drives HI/LO to the write-back mux for `mfhi`/`mflo`. The control FSM starts an operation with a one-cycle start pulse and waits in a stall state until `done`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; iteration count equals `WIDTH`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `a` in WIDTH: rs operand (multiplicand / dividend), two's complement.
- `b` in WIDTH: rt operand (multiplier / divisor), two's complement.
- `mult_start` in 1: one-cycle request for a signed multiply.
- `div_start` in 1: one-cycle request for a signed divide.
- `hi_out` out WIDTH: HI register (product[63:32] or remainder).
- `lo_out` out WIDTH: LO register (product[31:0] or quotient).
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in the same cycle.
- `div_zero` out 1: pulses with `done` when a divide had `b == 0`.

## Operation
- States: IDLE, MUL, DIV_PREP, DIV, DIV_FIX, DONE.
- IDLE:
  - Starts are sampled only here.
  - `a` and `b` are latched on the accepting edge.
  - If `mult_start` and `div_start` are both high, multiply wins.
- Multiply (MUL, `WIDTH` cycles):
  - Booth radix-2 over the product accumulator {P_hi, P_lo, q_-1}.
  - Each step adds, subtracts or skips the multiplicand per {q0, q_-1}, then arithmetic-shifts right by 1.
  - Adder is WIDTH+1 bits to avoid overflow at multiplicand = -2^31.
- Divide:
  - `b == 0` in IDLE → go straight to DONE with `div_zero` = 1; HI/LO are not written.
  - DIV_PREP (1 cycle): take absolute values, record quotient and remainder signs.
  - DIV (`WIDTH` cycles): restoring shift-subtract on unsigned magnitudes.
  - DIV_FIX (1 cycle): negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Quotient truncates toward zero.
  - -2^31 / -1 → LO = 0x8000_0000, HI = 0 (no trap).
- DONE (1 cycle):
  - Commit HI/LO, pulse `done`, return to IDLE.
  - A start in this cycle is ignored.
- A start while `busy` is ignored; the operation in flight is unaffected.
- HI/LO change only on a DONE commit or on reset; they hold across idle cycles.
- Reset asserted mid-operation aborts immediately: state = IDLE, accumulators cleared.

## Timing
- Reset values: `hi_out` = 0, `lo_out` = 0, `busy` = 0, `done` = 0, `div_zero` = 0; state = IDLE.
- Start accepted on edge 0.
- Multiply: `busy` high in cycles 1..32; `done` pulses in cycle 33; latency 33.
- Divide: `busy` high in cycles 1..34; `done` pulses in cycle 35; latency 35.
- Divide by zero: `done` and `div_zero` pulse in cycle 1; `busy` never rises.
- `busy` and `done` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `muldiv_pkg`:
  - state enum;
  - `WIDTH` default;
  - iteration-counter width `$clog2(WIDTH+1)`;
  - constant `INT_MIN`.
- Sub-module `div_restore_step`: combinational single iteration taking (remainder, quotient, divisor) and producing the next (remainder, quotient). It is instantiated once; the Booth step stays inline.
- One shared counter serves both MUL and DIV.

## Test plan
- 7 × -3: pulse `mult_start` → `done` at cycle 33, HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB.
- 0x8000_0000 × 0x8000_0000 → HI = 0x4000_0000, LO = 0.
- -7 / 2 → LO = 0xFFFF_FFFD (-3), HI = 0xFFFF_FFFF (-1), `done` at cycle 35, `div_zero` = 0.
- 5 / 0 → `done` and `div_zero` in cycle 1; HI/LO keep their prior values; `busy` stays 0.
- Simultaneous starts with `a` = 3, `b` = 4 → multiply runs, LO = 12. A `div_start` at cycle 10 is ignored; the result is unchanged.
- Reset at cycle 15 of a divide → all outputs 0 on the asynchronous edge. A fresh 100 / 7 after release gives LO = 14, HI = 2.
